// File: rtl/prog_run_ctrl_pkg.sv
// Shared run-control definitions: FSM states, program slot count and base-address table.
// The PC, assembler scripts and benches import the same table.
package prog_ctrl_pkg;
   localparam int L      = 10;
   localparam int NPROG  = 3;
   localparam int PIDX_W = (NPROG > 1) ? $clog2(NPROG) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, FINISH = 2'd3} state_t;

   localparam logic [L-1:0] PROG_BASE [NPROG] = '{10'h000, 10'h100, 10'h200};

   function automatic logic [L-1:0] base_addr(input logic [PIDX_W-1:0] idx);
      base_addr = '0;
      for (int i = 0; i < NPROG; i++)
         if (idx == PIDX_W'(i)) base_addr = PROG_BASE[i];
   endfunction

   function automatic logic [PIDX_W-1:0] next_idx(input logic [PIDX_W-1:0] idx);
      next_idx = (idx == PIDX_W'(NPROG - 1)) ? '0 : idx + 1'b1;
   endfunction
endpackage

// File: rtl/prog_run_ctrl_if.sv
// Harness/PC-facing signal bundle of the run-control sequencer.
interface prog_run_ctrl_if #(parameter int CYC_W = 16);
   import prog_ctrl_pkg::*;

   logic              Start;
   logic              HaltInsn;
   logic              PcLoad;
   logic [L-1:0]      LoadAddr;
   logic              PcHold;
   logic              CoreEn;
   logic              Done;
   logic              AllDone;
   logic              Timeout;
   logic [PIDX_W-1:0] ProgIdx;
   logic [CYC_W-1:0]  CycleCount;

   modport slave (
      input  Start, HaltInsn,
      output PcLoad, LoadAddr, PcHold, CoreEn, Done, AllDone, Timeout, ProgIdx, CycleCount
   );

   modport master (
      output Start, HaltInsn,
      input  PcLoad, LoadAddr, PcHold, CoreEn, Done, AllDone, Timeout, ProgIdx, CycleCount
   );
endinterface

// File: rtl/prog_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         Clk,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_q
);
   logic [W-1:0] r_q;

   always_ff @(posedge Clk) begin
      if (i_clr)
         r_q <= '0;
      else if (i_en && (r_q != '1))
         r_q <= r_q + 1'b1;
   end

   assign o_q = r_q;
endmodule

// File: rtl/prog_run_ctrl.sv
// Run-control sequencer: loads the PC with the slot base, runs the core until halt or
// cycle budget, then freezes the core, flags completion and advances to the next slot.
module prog_run_ctrl
   import prog_ctrl_pkg::*;
#(
   parameter int CYC_W   = 16,
   parameter int MAX_CYC = 4096
) (
   input  logic              Clk,
   input  logic              Reset,
   prog_run_ctrl_if.slave    bus
);
   state_t            r_state, w_next;
   logic              r_start_q;
   logic [PIDX_W-1:0] r_prog_idx;
   logic              r_done, r_all_done, r_timeout;
   logic              w_start_acc, w_budget_hit, w_run_end;
   logic              w_pc_load, w_pc_hold, w_core_en;
   logic [CYC_W-1:0]  w_cycles;

   // Only a fresh rising edge seen while idle starts a program; edges elsewhere are dropped.
   assign w_start_acc  = bus.Start && !r_start_q && (r_state == IDLE);
   assign w_budget_hit = (w_cycles == CYC_W'(MAX_CYC - 1));
   assign w_run_end    = (r_state == RUN) && (bus.HaltInsn || w_budget_hit);

   sat_counter #(.W(CYC_W)) u_cycles (
      .Clk   (Clk),
      .i_clr (Reset || w_start_acc),
      .i_en  (r_state == RUN),
      .o_q   (w_cycles)
   );

   always_ff @(posedge Clk) begin
      if (Reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_pc_load = 1'b0;
      w_pc_hold = 1'b1;
      w_core_en = 1'b0;
      case (r_state)
         IDLE:    if (w_start_acc) w_next = LOAD;
         LOAD: begin
            w_pc_load = 1'b1;
            w_pc_hold = 1'b0;
            w_next    = RUN;
         end
         RUN: begin
            w_pc_hold = 1'b0;
            w_core_en = 1'b1;
            if (w_run_end) w_next = FINISH;
         end
         FINISH:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_start_q  <= 1'b0;
         r_prog_idx <= '0;
         r_done     <= 1'b0;
         r_all_done <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_start_q <= bus.Start;
         if (w_start_acc) begin
            r_done     <= 1'b0;
            r_all_done <= 1'b0;
            r_timeout  <= 1'b0;
         end
         // Halt takes priority over the budget when both land on the same edge.
         if (w_run_end) begin
            r_done <= 1'b1;
            if (r_prog_idx == PIDX_W'(NPROG - 1)) r_all_done <= 1'b1;
            if (!bus.HaltInsn) r_timeout <= 1'b1;
         end
         if (r_state == FINISH) r_prog_idx <= next_idx(r_prog_idx);
      end
   end

   assign bus.PcLoad     = w_pc_load;
   assign bus.PcHold     = w_pc_hold;
   assign bus.CoreEn     = w_core_en;
   assign bus.LoadAddr   = base_addr(r_prog_idx);
   assign bus.Done       = r_done;
   assign bus.AllDone    = r_all_done;
   assign bus.Timeout    = r_timeout;
   assign bus.ProgIdx    = r_prog_idx;
   assign bus.CycleCount = w_cycles;
endmodule

// File: tb/tb_prog_run_ctrl.sv
// Bench for prog_run_ctrl: run-timeline model checked every cycle plus directed literal checks.
module tb_prog_run_ctrl;
   import prog_ctrl_pkg::*;

   localparam int CYC_W = 16;
   localparam int MAXC  = 8;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   prog_run_ctrl_if #(.CYC_W(CYC_W)) bus ();
   prog_run_ctrl #(.CYC_W(CYC_W), .MAX_CYC(MAXC)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Model: m_since counts cycles since an accepted Start (1 = load cycle, 2.. = run cycles);
   // m_end is the cycle index of the finish cycle once the run has ended.
   bit m_on = 0, m_sq, m_done, m_all, m_to;
   int m_since, m_end, m_idx, m_cnt;

   always @(posedge Clk) begin
      if (Reset) begin
         m_on = 1; m_sq = 0; m_done = 0; m_all = 0; m_to = 0;
         m_since = 0; m_end = 0; m_idx = 0; m_cnt = 0;
      end else if (m_on) begin
         if (m_since == 0) begin
            if (bus.Start && !m_sq) begin
               m_since = 1; m_done = 0; m_all = 0; m_to = 0; m_cnt = 0;
            end
         end else if (m_end != 0 && m_since == m_end) begin
            m_since = 0; m_end = 0; m_idx = (m_idx + 1) % NPROG;
         end else begin
            if (m_since >= 2) begin
               if (m_cnt < (1 << CYC_W) - 1) m_cnt++;
               if (bus.HaltInsn || (m_since - 1) == MAXC) begin
                  m_end  = m_since + 1;
                  m_done = 1;
                  if (m_idx == NPROG - 1) m_all = 1;
                  if (!bus.HaltInsn) m_to = 1;
               end
            end
            m_since++;
         end
         m_sq = bus.Start;
      end
   end

   bit e_ld, e_rn;
   always @(negedge Clk) begin
      if (m_on) begin
         e_ld = (m_since == 1);
         e_rn = (m_since >= 2) && !(m_end != 0 && m_since == m_end);
         chk("m_PcLoad",     32'(bus.PcLoad),     32'(e_ld));
         chk("m_PcHold",     32'(bus.PcHold),     32'(!(e_ld || e_rn)));
         chk("m_CoreEn",     32'(bus.CoreEn),     32'(e_rn));
         chk("m_LoadAddr",   32'(bus.LoadAddr),   32'(PROG_BASE[m_idx]));
         chk("m_Done",       32'(bus.Done),       32'(m_done));
         chk("m_AllDone",    32'(bus.AllDone),    32'(m_all));
         chk("m_Timeout",    32'(bus.Timeout),    32'(m_to));
         chk("m_ProgIdx",    32'(bus.ProgIdx),    32'(m_idx));
         chk("m_CycleCount", 32'(bus.CycleCount), 32'(m_cnt));
      end
   end

   task automatic tick();
      @(negedge Clk);
   endtask

   // Starts from an idle negedge; halt_at = 0 means never halt (runs into the budget).
   task automatic run_prog(input int halt_at, input logic [31:0] exp_addr,
                           input logic [31:0] exp_cnt, input logic [31:0] exp_to);
      int n;
      n = (halt_at != 0 && halt_at <= MAXC) ? halt_at : MAXC;
      bus.Start = 1'b1; tick();
      chk("load_PcLoad", 32'(bus.PcLoad), 32'd1);
      chk("load_Addr",   32'(bus.LoadAddr), exp_addr);
      bus.Start = 1'b0; tick();
      chk("run_CoreEn",  32'(bus.CoreEn), 32'd1);
      for (int r = 1; r < n; r++) tick();
      bus.HaltInsn = (halt_at == n); tick();
      bus.HaltInsn = 1'b0;
      chk("fin_Done",    32'(bus.Done), 32'd1);
      chk("fin_PcHold",  32'(bus.PcHold), 32'd1);
      chk("fin_CoreEn",  32'(bus.CoreEn), 32'd0);
      chk("fin_Cycles",  32'(bus.CycleCount), exp_cnt);
      chk("fin_Timeout", 32'(bus.Timeout), exp_to);
      tick();
   endtask

   initial begin
      Reset = 1'b1; bus.Start = 1'b0; bus.HaltInsn = 1'b0;
      repeat (3) tick();
      chk("rst_PcHold",  32'(bus.PcHold), 32'd1);
      chk("rst_CoreEn",  32'(bus.CoreEn), 32'd0);
      chk("rst_ProgIdx", 32'(bus.ProgIdx), 32'd0);
      chk("rst_Done",    32'(bus.Done), 32'd0);
      Reset = 1'b0; tick();

      run_prog(5, 32'h000, 32'd5, 32'd0);
      chk("t1_ProgIdx", 32'(bus.ProgIdx), 32'd1);

      run_prog(3, 32'h100, 32'd3, 32'd0);
      chk("t2_AllDone_mid", 32'(bus.AllDone), 32'd0);
      run_prog(2, 32'h200, 32'd2, 32'd0);
      chk("t2_AllDone", 32'(bus.AllDone), 32'd1);
      chk("t2_ProgIdx", 32'(bus.ProgIdx), 32'd0);

      run_prog(0, 32'h000, 32'd8, 32'd1);
      chk("t3_AllDone_clr", 32'(bus.AllDone), 32'd0);
      run_prog(8, 32'h100, 32'd8, 32'd0);

      bus.Start = 1'b1;
      repeat (50) tick();
      chk("t4_held_ProgIdx", 32'(bus.ProgIdx), 32'd0);
      chk("t4_held_Timeout", 32'(bus.Timeout), 32'd1);
      chk("t4_held_CoreEn",  32'(bus.CoreEn), 32'd0);
      bus.Start = 1'b0; tick();

      bus.Start = 1'b1; tick();
      bus.Start = 1'b0; tick();
      bus.Start = 1'b1; tick();
      bus.Start = 1'b0; tick();
      bus.HaltInsn = 1'b1; tick();
      bus.HaltInsn = 1'b0; bus.Start = 1'b1; tick();
      bus.Start = 1'b0; tick(); tick();
      chk("t5_ProgIdx", 32'(bus.ProgIdx), 32'd1);
      chk("t5_PcLoad",  32'(bus.PcLoad), 32'd0);
      chk("t5_Cycles",  32'(bus.CycleCount), 32'd3);

      bus.Start = 1'b1; tick();
      bus.Start = 1'b0; tick(); tick(); tick();
      chk("t6_pre_CoreEn", 32'(bus.CoreEn), 32'd1);
      Reset = 1'b1; tick();
      chk("t6_CoreEn",  32'(bus.CoreEn), 32'd0);
      chk("t6_PcHold",  32'(bus.PcHold), 32'd1);
      chk("t6_ProgIdx", 32'(bus.ProgIdx), 32'd0);
      chk("t6_Cycles",  32'(bus.CycleCount), 32'd0);
      chk("t6_Done",    32'(bus.Done), 32'd0);
      Reset = 1'b0; tick();

      bus.HaltInsn = 1'b1; repeat (3) tick();
      chk("t7_idle_Done", 32'(bus.Done), 32'd0);
      bus.Start = 1'b1; tick();
      bus.Start = 1'b0;
      chk("t7_load_PcLoad", 32'(bus.PcLoad), 32'd1);
      tick();
      chk("t7_run_CoreEn", 32'(bus.CoreEn), 32'd1);
      chk("t7_run_Done",   32'(bus.Done), 32'd0);
      bus.HaltInsn = 1'b0; tick(); tick();
      bus.HaltInsn = 1'b1; tick();
      bus.HaltInsn = 1'b0;
      chk("t7_fin_Cycles", 32'(bus.CycleCount), 32'd3);
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
